// File: rtl/ro_pair_counter_if.sv
// Request/response bus between the challenge/response controller and the
// RO pair counter. The controller is the master; the counter is the slave.
interface ro_pair_counter_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [3:0]       challenge;
  logic             busy;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_bit;
  logic             tie;
  logic             sat;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  modport master (
    output start, challenge, resp_ready,
    input  busy, resp_valid, resp_bit, tie, sat, cnt_a, cnt_b
  );

  modport slave (
    input  start, challenge, resp_ready,
    output busy, resp_valid, resp_bit, tie, sat, cnt_a, cnt_b
  );
endinterface

// File: rtl/ro_pair_counter.sv
// RO pair counter: drives a challenge and enable into two RO slices, counts
// synchronized rising edges of each oscillator over a fixed window, compares
// the two counts and returns one response bit over a valid/ready handshake.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; challenge outputs and results are 0
// SETTLE  | ROs enabled, letting them stabilise; counters held at 0
// COUNT   | window open; each detected edge increments its counter
// COMPARE | ROs disabled; final counts compared and loaded into results
// DONE    | response valid, held until resp_valid & resp_ready
module ro_pair_counter #(
  parameter int CNT_W       = 16,
  parameter int WINDOW      = 1024,
  parameter int SETTLE      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  ro_pair_counter_if.slave bus,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             ro_en,
  output logic             sel_a,
  output logic             bx_a,
  output logic             sel_b,
  output logic             bx_b
);

  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [TMR_W-1:0]       tmr;
  logic                   tmr_tc;
  logic [SYNC_STAGES-1:0] sync_a, sync_b;
  logic                   prev_a, prev_b;
  logic                   edge_a, edge_b;
  logic [CNT_W-1:0]       run_a, run_b;
  logic                   sat_run;
  logic [3:0]             chal;
  logic                   res_bit, res_tie, res_sat;
  logic [CNT_W-1:0]       res_cnt_a, res_cnt_b;
  logic                   busy_c, valid_c;

  assign tmr_tc = (tmr == '0);
  assign edge_a = sync_a[SYNC_STAGES-1] & ~prev_a;
  assign edge_b = sync_b[SYNC_STAGES-1] & ~prev_b;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    ro_en     = 1'b0;
    busy_c    = 1'b1;
    valid_c   = 1'b0;
    case (state)
      S_IDLE: begin
        busy_c = 1'b0;
        if (bus.start) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        ro_en = 1'b1;
        if (tmr_tc) state_nxt = S_COUNT;
      end
      S_COUNT: begin
        ro_en = 1'b1;
        if (tmr_tc) state_nxt = S_COMPARE;
      end
      S_COMPARE: state_nxt = S_DONE;
      S_DONE: begin
        valid_c = 1'b1;
        if (bus.resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Phase timer: down-counter reloaded per phase, terminal count at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr <= '0;
    end else begin
      case (state)
        S_IDLE:   if (bus.start) tmr <= TMR_W'(SETTLE - 1);
        S_SETTLE: tmr <= tmr_tc ? TMR_W'(WINDOW - 1) : tmr - 1'b1;
        S_COUNT:  if (!tmr_tc) tmr <= tmr - 1'b1;
        default:  tmr <= '0;
      endcase
    end
  end

  // Synchronizer chains plus one delay flop each for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      prev_a <= 1'b0;
      prev_b <= 1'b0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], ro_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], ro_b};
      prev_a <= sync_a[SYNC_STAGES-1];
      prev_b <= sync_b[SYNC_STAGES-1];
    end
  end

  // Challenge capture, saturating edge counters and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      chal      <= '0;
      run_a     <= '0;
      run_b     <= '0;
      sat_run   <= 1'b0;
      res_bit   <= 1'b0;
      res_tie   <= 1'b0;
      res_sat   <= 1'b0;
      res_cnt_a <= '0;
      res_cnt_b <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) chal <= bus.challenge;
        S_SETTLE: begin
          run_a   <= '0;
          run_b   <= '0;
          sat_run <= 1'b0;
        end
        S_COUNT: begin
          if (edge_a && (run_a != '1)) run_a <= run_a + 1'b1;
          if (edge_b && (run_b != '1)) run_b <= run_b + 1'b1;
          sat_run <= sat_run | (edge_a & (&run_a)) | (edge_b & (&run_b));
        end
        S_COMPARE: begin
          res_cnt_a <= run_a;
          res_cnt_b <= run_b;
          res_bit   <= (run_a > run_b);
          res_tie   <= (run_a == run_b);
          res_sat   <= sat_run;
        end
        S_DONE: begin
          if (bus.resp_ready) begin
            chal      <= '0;
            res_bit   <= 1'b0;
            res_tie   <= 1'b0;
            res_sat   <= 1'b0;
            res_cnt_a <= '0;
            res_cnt_b <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = busy_c;
  assign bus.resp_valid = valid_c;
  assign bus.resp_bit   = res_bit;
  assign bus.tie        = res_tie;
  assign bus.sat        = res_sat;
  assign bus.cnt_a      = res_cnt_a;
  assign bus.cnt_b      = res_cnt_b;

  assign bx_a  = chal[0];
  assign sel_a = chal[1];
  assign bx_b  = chal[2];
  assign sel_b = chal[3];

endmodule

// File: tb/tb_ro_pair_counter.sv
// Bench for ro_pair_counter: randomized challenges and RO waveforms, expected
// responses from a window edge-count model, checked by a decoupled monitor.
module tb_ro_pair_counter;

  localparam int CNT_W  = 6;
  localparam int WINDOW = 200;
  localparam int SETTLE = 5;
  localparam int SYNC   = 3;
  localparam int MAXC   = (1 << CNT_W) - 1;
  localparam int GUARD  = 3;

  typedef struct {
    int         ca;
    int         cb;
    bit         rb;
    bit         tie;
    bit         sat;
    int         start_cyc;
    int         stall;
    logic [3:0] ch;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic ro_a, ro_b, ro_en, sel_a, bx_a, sel_b, bx_b;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  exp_t expq[$];

  // RO waveform description for the current challenge; kb is the clock edge
  // at which START is sampled.
  int kb = -100000;
  int per_a = 2, ph_a = 0, per_b = 2, ph_b = 0;

  ro_pair_counter_if #(.CNT_W(CNT_W)) bus ();

  ro_pair_counter #(
    .CNT_W(CNT_W), .WINDOW(WINDOW), .SETTLE(SETTLE), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en(ro_en), .sel_a(sel_a), .bx_a(bx_a), .sel_b(sel_b), .bx_b(bx_b)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  function automatic logic [21:0] all_out();
    return {bus.busy, ro_en, bus.resp_valid, bus.resp_bit, bus.tie, bus.sat,
            bus.cnt_a, bus.cnt_b, sel_b, bx_b, sel_a, bx_a};
  endfunction

  function automatic logic [3:0] chal_out();
    return {sel_b, bx_b, sel_a, bx_a};
  endfunction

  // Oscillator level seen at clock edge j. The waveform is forced low in a
  // guard band around both window boundaries so boundary cases stay unambiguous.
  function automatic bit wave(input int j, input int per, input int ph);
    int d, b1, b2;
    d  = j + SYNC;
    b1 = kb + SETTLE + 1;
    b2 = kb + SETTLE + WINDOW;
    if ((d >= b1 - GUARD && d <= b1 + GUARD) || (d >= b2 - GUARD && d <= b2 + GUARD))
      return 1'b0;
    return ((j + ph) % per) < (per / 2);
  endfunction

  // Number of rising transitions whose synchronized detection falls inside
  // the WINDOW counting cycles.
  function automatic int count_edges(input int per, input int ph);
    int n, j;
    n = 0;
    for (int d = kb + SETTLE + 1; d <= kb + SETTLE + WINDOW; d++) begin
      j = d - SYNC;
      if (wave(j, per, ph) && !wave(j - 1, per, ph)) n++;
    end
    return n;
  endfunction

  // RO drivers: change away from the sampling edge.
  initial begin
    ro_a = 1'b0;
    ro_b = 1'b0;
    forever begin
      @(negedge clk);
      ro_a = wave(cyc + 1, per_a, ph_a);
      ro_b = wave(cyc + 1, per_b, ph_b);
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    if (bus.busy) chk("idle_timeout", 1, 0);
  endtask

  // noise: 0 quiet, 1 random START/CHALLENGE while busy, 2 START held high.
  task automatic run_chal(input logic [3:0] ch, input int pa, input int pha,
                          input int pb, input int phb, input int stall,
                          input int noise, input bit do_rst);
    exp_t e;
    int   n, na, nb;
    wait_idle();
    kb    = cyc + 1;
    per_a = pa; ph_a = pha; per_b = pb; ph_b = phb;
    bus.challenge = ch;
    bus.start     = 1'b1;
    if (!do_rst) begin
      na = count_edges(pa, pha);
      nb = count_edges(pb, phb);
      e.sat       = (na > MAXC) || (nb > MAXC);
      e.ca        = (na > MAXC) ? MAXC : na;
      e.cb        = (nb > MAXC) ? MAXC : nb;
      e.rb        = e.ca > e.cb;
      e.tie       = e.ca == e.cb;
      e.start_cyc = cyc;
      e.stall     = stall;
      e.ch        = ch;
      expq.push_back(e);
    end
    @(posedge clk); #2;
    chk("accept_busy", bus.busy, 1);
    chk("accept_ro_en", ro_en, 1);
    chk("accept_chal", chal_out(), ch);
    bus.start = (noise == 2);
    n = 0;
    while (bus.busy && n < 3000) begin
      if (do_rst && n == SETTLE + WINDOW / 2) begin
        rst = 1'b1;
        @(posedge clk); #2;
        chk("rst_mid_count", all_out(), 0);
        rst = 1'b0;
      end else begin
        chk("chal_held", chal_out(), ch);
        if (noise == 1) bus.start = 1'($urandom_range(0, 1));
        if (noise != 0) bus.challenge = 4'($urandom_range(0, 15));
        @(posedge clk); #2;
        n++;
      end
    end
    bus.start = 1'b0;
    if (bus.busy) chk("busy_timeout", 1, 0);
    @(posedge clk); #2;
    chk("no_spurious_accept", bus.busy, 0);
  endtask

  // Monitor: pops the scoreboard on each new response, checks stability
  // while stalled, and checks the cleared outputs after the handshake.
  initial begin
    exp_t cur;
    int   stall_left;
    bit   have_cur, hs_pending;
    have_cur = 0; hs_pending = 0; stall_left = 0;
    bus.resp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        have_cur = 0; hs_pending = 0;
      end else if (hs_pending) begin
        chk("clear_after_hs", all_out(), 0);
        hs_pending = 0; have_cur = 0;
        bus.resp_ready = 1'($urandom_range(0, 1));
      end else if (bus.resp_valid) begin
        if (!have_cur) begin
          if (expq.size() == 0) begin
            chk("unexpected_resp", 1, 0);
            stall_left = 0;
          end else begin
            cur = expq.pop_front();
            have_cur = 1;
            chk("cnt_a", bus.cnt_a, cur.ca);
            chk("cnt_b", bus.cnt_b, cur.cb);
            chk("resp_bit", bus.resp_bit, cur.rb);
            chk("tie", bus.tie, cur.tie);
            chk("sat", bus.sat, cur.sat);
            chk("latency", cyc - cur.start_cyc, SETTLE + WINDOW + 2);
            chk("done_ro_en", ro_en, 0);
            chk("done_busy", bus.busy, 1);
            chk("done_chal", chal_out(), cur.ch);
            stall_left = cur.stall;
          end
        end else begin
          chk("stable_in_done",
              {bus.resp_bit, bus.tie, bus.sat, bus.cnt_a, bus.cnt_b},
              {cur.rb, cur.tie, cur.sat, 6'(cur.ca), 6'(cur.cb)});
        end
        if (stall_left > 0) begin
          bus.resp_ready = 1'b0;
          stall_left--;
        end else begin
          bus.resp_ready = 1'b1;
          hs_pending = 1;
        end
      end else begin
        if (have_cur) begin
          chk("valid_dropped", 1, 0);
          have_cur = 0;
        end
        bus.resp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit reached, required summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.challenge = 4'd0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_state", all_out(), 0);
    rst = 1'b0;

    run_chal(4'b0110, 6, 1, 6, 1, 0, 0, 0);   // identical oscillators -> tie
    run_chal(4'b1001, 7, 0, 9, 4, 1, 0, 0);   // A faster
    run_chal(4'b0011, 11, 2, 5, 0, 2, 1, 0);  // B faster
    run_chal(4'b1111, 2, 0, 10, 3, 0, 0, 0);  // A saturates
    run_chal(4'b1010, 8, 3, 6, 0, 50, 2, 0);  // START held, long stall
    run_chal(4'b0101, 4, 0, 3, 1, 0, 0, 1);   // reset mid-COUNT
    run_chal(4'b1100, 5, 0, 5, 2, 1, 0, 0);   // clean run after reset
    for (int i = 0; i < 14; i++) begin
      run_chal(4'($urandom_range(0, 15)),
               $urandom_range(2, 14), $urandom_range(0, 13),
               $urandom_range(2, 14), $urandom_range(0, 13),
               $urandom_range(0, 3), $urandom_range(0, 2), 0);
    end

    wait_idle();
    repeat (5) @(posedge clk);
    #2;
    chk("queue_empty", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
